// File: rtl/reg_file_param.sv
// reg_file_param: parametrised register file with two write ports, two
// combinational read ports, optional write-to-read bypass, optional hardwired
// zero register and a per-register pending scoreboard.
module reg_file_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2,
  output logic              busy_1,
  output logic              busy_2,
  input  logic              wr_en_a,
  input  logic [ADDR_W-1:0] wr_addr_a,
  input  logic [DATA_W-1:0] wr_data_a,
  input  logic              wr_en_b,
  input  logic [ADDR_W-1:0] wr_addr_b,
  input  logic [DATA_W-1:0] wr_data_b,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pendingNext;
  logic              wrA;
  logic              wrB;
  logic              rsv;

  logic [1:0][ADDR_W-1:0] rdAddr;
  logic [1:0][DATA_W-1:0] rdData;
  logic [1:0]             rdBusy;

  // Qualified enables: anything aimed at the hardwired zero register is dropped here,
  // so neither storage, scoreboard nor bypass ever sees it.
  always_comb begin
    wrA = wr_en_a;
    wrB = wr_en_b;
    rsv = rsv_en;
    if (ZERO_REG != 0) begin
      if (wr_addr_a == '0) wrA = 1'b0;
      if (wr_addr_b == '0) wrB = 1'b0;
      if (rsv_addr  == '0) rsv = 1'b0;
    end
  end

  // Scoreboard update: writes retire a pending bit, a reservation applied last
  // re-arms it so a new producer in the same cycle wins.
  always_comb begin
    pendingNext = pending;
    if (wrA) pendingNext[wr_addr_a] = 1'b0;
    if (wrB) pendingNext[wr_addr_b] = 1'b0;
    if (rsv) pendingNext[rsv_addr]  = 1'b1;
  end

  // Storage and scoreboard registers; port B is applied after A so it wins a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
      pending <= '0;
    end else begin
      if (wrA) regs[wr_addr_a] <= wr_data_a;
      if (wrB) regs[wr_addr_b] <= wr_data_b;
      pending <= pendingNext;
    end
  end

  assign rdAddr = {rd_addr_2, rd_addr_1};

  // Read ports: stored value, optionally overridden by a same-cycle write (B over A);
  // busy comes from registered pending bits only.
  always_comb begin
    rdData = '0;
    rdBusy = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      rdData[p] = regs[rdAddr[p]];
      if (BYPASS != 0 && !rst) begin
        if (wrB && wr_addr_b == rdAddr[p])      rdData[p] = wr_data_b;
        else if (wrA && wr_addr_a == rdAddr[p]) rdData[p] = wr_data_a;
      end
      rdBusy[p] = pending[rdAddr[p]];
      if (ZERO_REG != 0 && rdAddr[p] == '0) begin
        rdData[p] = '0;
        rdBusy[p] = 1'b0;
      end
    end
  end

  assign rd_data_1 = rdData[0];
  assign rd_data_2 = rdData[1];
  assign busy_1    = rdBusy[0];
  assign busy_2    = rdBusy[1];

endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: directed bench for reg_file_param. Three 8-bit instances
// (default, no bypass, zero register) share one stimulus; a 16-bit/16-entry
// instance is driven separately.
module tb_reg_file_param;

  logic clk;
  logic rst;

  // shared 8-bit stimulus
  logic [1:0] rdAddr1, rdAddr2, waA, waB, rsvAddr;
  logic [7:0] wdA, wdB;
  logic       weA, weB, rsvEn;
  logic [7:0] rd1 [3];
  logic [7:0] rd2 [3];
  logic [2:0] bz1, bz2;

  // wide instance stimulus
  logic [3:0]  wRdAddr1, wRdAddr2, wWaA, wWaB, wRsvAddr;
  logic [15:0] wWdA, wWdB, wRd1, wRd2;
  logic        wWeA, wWeB, wRsvEn, wBz1, wBz2;

  int total = 0;
  int bad   = 0;

  reg_file_param #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0), .BYPASS(1)) u0 (
    .clk(clk), .rst(rst), .rd_addr_1(rdAddr1), .rd_addr_2(rdAddr2),
    .rd_data_1(rd1[0]), .rd_data_2(rd2[0]), .busy_1(bz1[0]), .busy_2(bz2[0]),
    .wr_en_a(weA), .wr_addr_a(waA), .wr_data_a(wdA),
    .wr_en_b(weB), .wr_addr_b(waB), .wr_data_b(wdB),
    .rsv_en(rsvEn), .rsv_addr(rsvAddr));

  reg_file_param #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0), .BYPASS(0)) u1 (
    .clk(clk), .rst(rst), .rd_addr_1(rdAddr1), .rd_addr_2(rdAddr2),
    .rd_data_1(rd1[1]), .rd_data_2(rd2[1]), .busy_1(bz1[1]), .busy_2(bz2[1]),
    .wr_en_a(weA), .wr_addr_a(waA), .wr_data_a(wdA),
    .wr_en_b(weB), .wr_addr_b(waB), .wr_data_b(wdB),
    .rsv_en(rsvEn), .rsv_addr(rsvAddr));

  reg_file_param #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1), .BYPASS(1)) u2 (
    .clk(clk), .rst(rst), .rd_addr_1(rdAddr1), .rd_addr_2(rdAddr2),
    .rd_data_1(rd1[2]), .rd_data_2(rd2[2]), .busy_1(bz1[2]), .busy_2(bz2[2]),
    .wr_en_a(weA), .wr_addr_a(waA), .wr_data_a(wdA),
    .wr_en_b(weB), .wr_addr_b(waB), .wr_data_b(wdB),
    .rsv_en(rsvEn), .rsv_addr(rsvAddr));

  reg_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) u3 (
    .clk(clk), .rst(rst), .rd_addr_1(wRdAddr1), .rd_addr_2(wRdAddr2),
    .rd_data_1(wRd1), .rd_data_2(wRd2), .busy_1(wBz1), .busy_2(wBz2),
    .wr_en_a(wWeA), .wr_addr_a(wWaA), .wr_data_a(wWdA),
    .wr_en_b(wWeB), .wr_addr_b(wWaB), .wr_data_b(wWdB),
    .rsv_en(wRsvEn), .rsv_addr(wRsvAddr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    weA = 1'b0; weB = 1'b0; rsvEn = 1'b0;
    wWeA = 1'b0; wWeB = 1'b0; wRsvEn = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    rdAddr1 = 2'd1; rdAddr2 = 2'd2; waA = '0; waB = '0; rsvAddr = '0; wdA = '0; wdB = '0;
    wRdAddr1 = '0; wRdAddr2 = '0; wWaA = '0; wWaB = '0; wRsvAddr = '0; wWdA = '0; wWdB = '0;

    // 1: reset overrides a write to r1
    weA = 1'b1; waA = 2'd1; wdA = 8'h0F;
    tick();
    rst = 1'b0; idle();
    #1;
    check("rst_rd1_r1", rd1[0], 8'h00);
    check("rst_rd2_r2", rd2[0], 8'h00);
    check("rst_busy1", bz1[0], 1'b0);
    check("rst_busy2", bz2[0], 1'b0);

    // 2: dual write to different addresses
    weA = 1'b1; waA = 2'd1; wdA = 8'h0F;
    weB = 1'b1; waB = 2'd2; wdB = 8'hF0;
    tick(); idle();
    #1;
    check("dual_r1", rd1[0], 8'h0F);
    check("dual_r2", rd2[0], 8'hF0);
    check("dual_r1_nobyp", rd1[1], 8'h0F);
    check("dual_r2_zreg", rd2[2], 8'hF0);

    // 2: collision on r3, B wins (also in the bypass path)
    rdAddr1 = 2'd3;
    weA = 1'b1; waA = 2'd3; wdA = 8'h11;
    weB = 1'b1; waB = 2'd3; wdB = 8'h22;
    #1;
    check("coll_bypass", rd1[0], 8'h22);
    check("coll_nobyp_old", rd1[1], 8'h00);
    tick(); idle();
    #1;
    check("coll_r3", rd1[0], 8'h22);
    check("coll_r3_nobyp", rd1[1], 8'h22);

    // 3: bypass of A write to r2
    rdAddr1 = 2'd2;
    weA = 1'b1; waA = 2'd2; wdA = 8'h5A;
    #1;
    check("byp_same_cycle", rd1[0], 8'h5A);
    check("nobyp_same_cycle", rd1[1], 8'hF0);
    tick(); idle();
    #1;
    check("nobyp_next", rd1[1], 8'h5A);

    // 4: scoreboard on r3
    rdAddr1 = 2'd3;
    rsvEn = 1'b1; rsvAddr = 2'd3;
    #1;
    check("rsv_not_yet", bz1[0], 1'b0);
    tick(); idle();
    #1;
    check("rsv_busy", bz1[0], 1'b1);
    check("rsv_stale", rd1[0], 8'h22);
    weB = 1'b1; waB = 2'd3; wdB = 8'h77;
    #1;
    check("rsv_busy_wrcyc", bz1[0], 1'b1);
    check("rsv_byp_data", rd1[0], 8'h77);
    tick(); idle();
    #1;
    check("wr_clears_busy", bz1[0], 1'b0);
    check("wr_data_77", rd1[0], 8'h77);
    rsvEn = 1'b1; rsvAddr = 2'd3;
    weA = 1'b1; waA = 2'd3; wdA = 8'h33;
    tick(); idle();
    #1;
    check("rsv_wr_data", rd1[0], 8'h33);
    check("rsv_wr_busy", bz1[0], 1'b1);

    // 5: zero register
    rdAddr1 = 2'd0; rdAddr2 = 2'd0;
    weA = 1'b1; waA = 2'd0; wdA = 8'hFF;
    rsvEn = 1'b1; rsvAddr = 2'd0;
    #1;
    check("zreg_wrcyc_rd1", rd1[2], 8'h00);
    check("zreg_wrcyc_rd2", rd2[2], 8'h00);
    check("r0_byp_plain", rd1[0], 8'hFF);
    tick(); idle();
    #1;
    check("zreg_rd1", rd1[2], 8'h00);
    check("zreg_busy1", bz1[2], 1'b0);
    check("zreg_busy2", bz2[2], 1'b0);
    check("r0_plain", rd1[0], 8'hFF);
    check("r0_plain_busy", bz1[0], 1'b1);

    // reset mid-reservation: no bypass while rst=1, no retention of write
    rdAddr1 = 2'd3; rdAddr2 = 2'd1;
    rst = 1'b1;
    weA = 1'b1; waA = 2'd1; wdA = 8'hAA;
    #1;
    check("rst_nobypass", rd2[0], 8'h0F);
    tick(); idle(); rst = 1'b0;
    #1;
    check("midrst_busy", bz1[0], 1'b0);
    check("midrst_r3", rd1[0], 8'h00);
    check("midrst_r1", rd2[0], 8'h00);

    // 6: wide instance
    wWeA = 1'b1; wWaA = 4'd15; wWdA = 16'hBEEF;
    wWeB = 1'b1; wWaB = 4'd0;  wWdB = 16'h1234;
    tick(); idle();
    wRdAddr1 = 4'd15; wRdAddr2 = 4'd0;
    #1;
    check("wide_r15", wRd1, 16'hBEEF);
    check("wide_r0", wRd2, 16'h1234);
    wRdAddr1 = 4'd5;
    wRsvEn = 1'b1; wRsvAddr = 4'd5;
    tick(); idle();
    #1;
    check("wide_busy", wBz1, 1'b1);
    rst = 1'b1;
    tick(); rst = 1'b0;
    wRdAddr1 = 4'd15;
    #1;
    check("wide_rst_r15", wRd1, 16'h0000);
    wRdAddr1 = 4'd5;
    #1;
    check("wide_rst_busy", wBz1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised multi-register file; successor to the fixed two-entry, 8-bit, single-write-port register file used by the datapath.
- Generalises data width and register count. Adds a second write port, optional same-cycle write-to-read bypass, an optional hardwired zero register, and a per-register pending scoreboard for multi-cycle producers.
- Sits between decode (read addresses, reservations) and writeback (ALU port A, memory/long-latency port B).

Parameters:
- DATA_W, 8, width of each register and all data ports.
- ADDR_W, 2, register address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 0, when 1 register 0 always reads 0, ignores writes and is never pending.
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports; when 0 reads show stored contents only.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_addr_1  in  ADDR_W  read port 1 address.
- rd_addr_2  in  ADDR_W  read port 2 address.
- rd_data_1  out  DATA_W  read port 1 data.
- rd_data_2  out  DATA_W  read port 2 data.
- busy_1  out  1  register at rd_addr_1 is pending.
- busy_2  out  1  register at rd_addr_2 is pending.
- wr_en_a  in  1  write port A enable.
- wr_addr_a  in  ADDR_W  write port A address.
- wr_data_a  in  DATA_W  write port A data.
- wr_en_b  in  1  write port B enable.
- wr_addr_b  in  ADDR_W  write port B address.
- wr_data_b  in  DATA_W  write port B data.
- rsv_en  in  1  mark a register pending.
- rsv_addr  in  ADDR_W  register to reserve.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, rst.
- Reset: at a rising edge with rst=1, all DEPTH registers are cleared to 0 and all pending bits are cleared. rst overrides every write and reservation in that cycle.
  - After the reset edge: rd_data_1 = rd_data_2 = 0 and busy_1 = busy_2 = 0 for any address.
- Reads are combinational, with zero latency from address to data.
- Writes commit at the rising edge when wr_en_x=1 and rst=0. Data is visible from stored contents in the following cycle.
- Write collision: if both ports write the same address in the same cycle, port B wins. Port A's data is discarded.
- Bypass (BYPASS=1, rst=0): when rd_addr_n equals an enabled write address in the current cycle, rd_data_n returns that write data. Port B has priority over port A.
  - No bypass while rst=1.
  - No bypass to register 0 when ZERO_REG=1.
- ZERO_REG=1:
  - rd_data_n = 0 and busy_n = 0 whenever rd_addr_n = 0.
  - Writes and reservations to address 0 are dropped.
- Scoreboard:
  - rsv_en=1 sets pending[rsv_addr] at the edge.
  - Any enabled write (A or B) to an address clears its pending bit at the edge.
  - Reservation and write to the same address in the same cycle: the write data commits and pending ends SET (the new producer wins).
  - busy_n reflects registered pending bits only; it is not bypassed.
  - Reading a pending register returns its current stored (stale) value. Stalling is the consumer's responsibility.
- Widths: all data is exactly DATA_W, with no extension or truncation.
- Addresses are always in range, since DEPTH = 2**ADDR_W.
- Reset mid-operation: outstanding reservations are lost and contents are zeroed. No write issued in the reset cycle is retained.

Test Plan:
1. Reset with default parameters: drive writes 0x0F to r1 with rst=1 -> after the edge, all rd_data = 0x00 and busy = 0; reading r1 gives 0x00.
2. Dual write, different addresses: A writes r1=0x0F, B writes r2=0xF0 -> next cycle rd_addr_1=1 gives 0x0F and rd_addr_2=2 gives 0xF0. Same-cycle collision, A r3=0x11 and B r3=0x22 -> r3 reads 0x22.
3. Bypass: BYPASS=1, A writes r2=0x5A while rd_addr_1=2 -> rd_data_1=0x5A in the same cycle. With BYPASS=0, the same stimulus gives the old value 0xF0 in that cycle and 0x5A the next.
4. Scoreboard: rsv r3 -> busy=1 for r3 from the next cycle. B writes r3=0x77 -> busy=0 and data 0x77 the following cycle. Same-cycle rsv r3 plus A write r3=0x33 -> r3=0x33 and busy=1.
5. ZERO_REG=1: A writes r0=0xFF and rsv r0 -> rd_data=0x00 and busy=0 for address 0, including in the write cycle.
6. Width/depth sweep: DATA_W=16, ADDR_W=4 -> write r15=0xBEEF and r0=0x1234 -> both read back correctly. Reset mid-reservation clears busy.
